// File: rtl/dmem_arb.sv
// dmem_arb: shares one 256 x 8 synchronous data RAM between two requesters.
//   Port 0 is the CPU load/store unit and port 1 is the debug/DMA loader.
//   The arbiter grants at most one access per cycle and drives the RAM
//   command lines. Read data returns to the requesting port one cycle
//   later with an rvalid strobe. It also keeps a saturating count of the
//   cycles in which both ports requested.
//
// Parameters:
//   FIXED_PRIO   0 = round-robin on ties, 1 = port 0 always wins ties
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   pX_req/we/addr/wdata            request from port X (X = 0, 1)
//   pX_gnt                          combinational grant to port X
//   pX_rvalid/rdata                 read return, one cycle after the grant
//   mem_wen/waddr/wdata/raddr       RAM command lines
//   mem_rdata                       RAM registered read data
//   conflict_cnt                    saturating count of contention cycles
//
// Handshake: a port raises req with we/addr/wdata valid and holds them
// stable until it sees gnt high. The access is taken at the rising edge
// that ends the cycle in which gnt is high. Dropping req before a grant
// withdraws the request.
module dmem_arb #(
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [7:0]  p0_addr,
  input  logic [7:0]  p0_wdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [7:0]  p1_addr,
  input  logic [7:0]  p1_wdata,
  output logic        p0_gnt,
  output logic        p1_gnt,
  output logic        p0_rvalid,
  output logic        p1_rvalid,
  output logic [7:0]  p0_rdata,
  output logic [7:0]  p1_rdata,
  output logic        mem_wen,
  output logic [7:0]  mem_waddr,
  output logic [7:0]  mem_wdata,
  output logic [7:0]  mem_raddr,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] conflict_cnt
);

  logic last_gnt;   // 0 = port 0 granted most recently, 1 = port 1
  logic rd_pend0;
  logic rd_pend1;
  logic both_req;

  assign both_req = p0_req & p1_req;

  // Grant selection. On a tie under round-robin, the port that did not win
  // last time is granted. last_gnt resets to 1, so port 0 wins the first tie.
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (!rst) begin
      if (both_req) begin
        if (FIXED_PRIO != 0) begin
          p0_gnt = 1'b1;
        end else if (last_gnt) begin
          p0_gnt = 1'b1;
        end else begin
          p1_gnt = 1'b1;
        end
      end else begin
        p0_gnt = p0_req;
        p1_gnt = p1_req;
      end
    end
  end

  // RAM command from the granted port. Unused lines are driven to 0.
  always_comb begin
    mem_wen   = 1'b0;
    mem_waddr = 8'h00;
    mem_wdata = 8'h00;
    mem_raddr = 8'h00;
    if (p0_gnt) begin
      if (p0_we) begin
        mem_wen   = 1'b1;
        mem_waddr = p0_addr;
        mem_wdata = p0_wdata;
      end else begin
        mem_raddr = p0_addr;
      end
    end else if (p1_gnt) begin
      if (p1_we) begin
        mem_wen   = 1'b1;
        mem_waddr = p1_addr;
        mem_wdata = p1_wdata;
      end else begin
        mem_raddr = p1_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt     <= 1'b1;
      rd_pend0     <= 1'b0;
      rd_pend1     <= 1'b0;
      conflict_cnt <= 16'h0000;
    end else begin
      if (p0_gnt) begin
        last_gnt <= 1'b0;
      end else if (p1_gnt) begin
        last_gnt <= 1'b1;
      end
      rd_pend0 <= p0_gnt & ~p0_we;
      rd_pend1 <= p1_gnt & ~p1_we;
      if (both_req && (conflict_cnt != 16'hFFFF)) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
    end
  end

  // A reset arriving the cycle after a read grant cancels that return, so
  // the pending flag is masked by rst as well as being cleared at the edge.
  assign p0_rvalid = rd_pend0 & ~rst;
  assign p1_rvalid = rd_pend1 & ~rst;
  assign p0_rdata  = p0_rvalid ? mem_rdata : 8'h00;
  assign p1_rdata  = p1_rvalid ? mem_rdata : 8'h00;

endmodule

// File: tb/tb_dmem_arb.sv
// Testbench for dmem_arb: table-driven vectors on a round-robin instance
// backed by a small RAM model, a fixed-priority sequence on a second
// instance, and a counter saturation run.
module tb_dmem_arb;

  logic clk;
  logic rst;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- round-robin instance ----------------
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [7:0]  p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [7:0]  p0_rdata, p1_rdata;
  logic        mem_wen;
  logic [7:0]  mem_waddr, mem_wdata, mem_raddr, mem_rdata;
  logic [15:0] conflict_cnt;

  dmem_arb #(.FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
    .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .conflict_cnt(conflict_cnt)
  );

  // 256 x 8 RAM with synchronous read and write
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (mem_wen) ram[mem_waddr] <= mem_wdata;
    mem_rdata <= ram[mem_raddr];
  end

  // ---------------- fixed-priority instance ----------------
  logic        f_p0_req, f_p0_we, f_p1_req, f_p1_we;
  logic [7:0]  f_p0_addr, f_p0_wdata, f_p1_addr, f_p1_wdata;
  logic        f_p0_gnt, f_p1_gnt, f_p0_rvalid, f_p1_rvalid;
  logic [7:0]  f_p0_rdata, f_p1_rdata;
  logic        f_mem_wen;
  logic [7:0]  f_mem_waddr, f_mem_wdata, f_mem_raddr;
  logic [7:0]  f_mem_rdata;
  logic [15:0] f_conflict_cnt;

  assign f_mem_rdata = 8'h5A;

  dmem_arb #(.FIXED_PRIO(1)) u_fp (
    .clk(clk), .rst(rst),
    .p0_req(f_p0_req), .p0_we(f_p0_we), .p0_addr(f_p0_addr), .p0_wdata(f_p0_wdata),
    .p1_req(f_p1_req), .p1_we(f_p1_we), .p1_addr(f_p1_addr), .p1_wdata(f_p1_wdata),
    .p0_gnt(f_p0_gnt), .p1_gnt(f_p1_gnt),
    .p0_rvalid(f_p0_rvalid), .p1_rvalid(f_p1_rvalid),
    .p0_rdata(f_p0_rdata), .p1_rdata(f_p1_rdata),
    .mem_wen(f_mem_wen), .mem_waddr(f_mem_waddr), .mem_wdata(f_mem_wdata),
    .mem_raddr(f_mem_raddr), .mem_rdata(f_mem_rdata),
    .conflict_cnt(f_conflict_cnt)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic        rst;
    logic        r0;
    logic        w0;
    logic [7:0]  a0;
    logic [7:0]  d0;
    logic        r1;
    logic        w1;
    logic [7:0]  a1;
    logic [7:0]  d1;
    logic        g0;
    logic        g1;
    logic        v0;
    logic        v1;
    logic [7:0]  rd0;
    logic [7:0]  rd1;
    logic        wen;
    logic [15:0] cnt;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl [NV];

  function automatic vec_t mk(
    input logic rs, input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
    input logic r1, input logic w1, input logic [7:0] a1, input logic [7:0] d1,
    input logic g0, input logic g1, input logic v0, input logic v1,
    input logic [7:0] rd0, input logic [7:0] rd1, input logic wen, input logic [15:0] cnt);
    vec_t v;
    v.rst = rs; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1;
    v.rd0 = rd0; v.rd1 = rd1; v.wen = wen; v.cnt = cnt;
    return v;
  endfunction

  // Drive inputs just after the rising edge.
  task automatic drive(input vec_t v);
    rst = v.rst;
    p0_req = v.r0; p0_we = v.w0; p0_addr = v.a0; p0_wdata = v.d0;
    p1_req = v.r1; p1_we = v.w1; p1_addr = v.a1; p1_wdata = v.d1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          rst r0 w0 a0     d0     r1 w1 a1     d1     g0 g1 v0 v1 rd0    rd1    wen cnt
    tbl[0]  = mk(1, 1, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 0, 16'd0);
    tbl[1]  = mk(1, 1, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 0, 16'd0);
    tbl[2]  = mk(0, 1, 1, 8'h10, 8'hA5, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 1, 16'd0);
    tbl[3]  = mk(0, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 0, 16'd0);
    tbl[4]  = mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 8'hA5, 8'h00, 0, 16'd0);
    tbl[5]  = mk(0, 1, 1, 8'h01, 8'h11, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 1, 16'd0);
    tbl[6]  = mk(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h02, 8'h22, 0, 1, 0, 0, 8'h00, 8'h00, 1, 16'd0);
    tbl[7]  = mk(0, 1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 0, 16'd0);
    tbl[8]  = mk(0, 1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, 0, 1, 1, 0, 8'h11, 8'h00, 0, 16'd1);
    tbl[9]  = mk(0, 1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, 1, 0, 0, 1, 8'h00, 8'h22, 0, 16'd2);
    tbl[10] = mk(0, 1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, 0, 1, 1, 0, 8'h11, 8'h00, 0, 16'd3);
    tbl[11] = mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 8'h00, 8'h22, 0, 16'd4);
    tbl[12] = mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h02, 8'h00, 0, 1, 0, 0, 8'h00, 8'h00, 0, 16'd4);
    tbl[13] = mk(1, 1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 0, 16'd4);
    tbl[14] = mk(0, 1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 0, 16'd0);
    tbl[15] = mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 8'h11, 8'h00, 0, 16'd1);

    // idle inputs, one reset edge before the table
    rst = 1'b1;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    f_p0_req = 0; f_p0_we = 0; f_p0_addr = 0; f_p0_wdata = 0;
    f_p1_req = 0; f_p1_we = 0; f_p1_addr = 8'h40; f_p1_wdata = 0;
    next_cycle();

    // ---- table: one row per cycle, checked at the falling edge ----
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i]);
      @(negedge clk);
      chk($sformatf("row%0d p0_gnt", i),    {15'd0, p0_gnt},    {15'd0, tbl[i].g0});
      chk($sformatf("row%0d p1_gnt", i),    {15'd0, p1_gnt},    {15'd0, tbl[i].g1});
      chk($sformatf("row%0d p0_rvalid", i), {15'd0, p0_rvalid}, {15'd0, tbl[i].v0});
      chk($sformatf("row%0d p1_rvalid", i), {15'd0, p1_rvalid}, {15'd0, tbl[i].v1});
      if (tbl[i].v0) chk($sformatf("row%0d p0_rdata", i), {8'd0, p0_rdata}, {8'd0, tbl[i].rd0});
      if (tbl[i].v1) chk($sformatf("row%0d p1_rdata", i), {8'd0, p1_rdata}, {8'd0, tbl[i].rd1});
      chk($sformatf("row%0d mem_wen", i),   {15'd0, mem_wen},   {15'd0, tbl[i].wen});
      chk($sformatf("row%0d conflict_cnt", i), conflict_cnt, tbl[i].cnt);
      next_cycle();
    end

    // ---- fixed priority: both request reads for 3 cycles ----
    rst = 1'b0;
    f_p0_req = 1; f_p1_req = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("fp c%0d p0_gnt", c), {15'd0, f_p0_gnt}, 16'd1);
      chk($sformatf("fp c%0d p1_gnt", c), {15'd0, f_p1_gnt}, 16'd0);
      if (c > 0) begin
        chk($sformatf("fp c%0d p0_rvalid", c), {15'd0, f_p0_rvalid}, 16'd1);
        chk($sformatf("fp c%0d p0_rdata", c), {8'd0, f_p0_rdata}, 16'h005A);
      end
      next_cycle();
    end
    f_p0_req = 0;
    @(negedge clk);
    chk("fp drop p1_gnt", {15'd0, f_p1_gnt}, 16'd1);
    chk("fp drop p0_gnt", {15'd0, f_p0_gnt}, 16'd0);
    chk("fp drop p0_rvalid", {15'd0, f_p0_rvalid}, 16'd1);
    next_cycle();
    f_p1_req = 0;
    @(negedge clk);
    chk("fp tail p1_rvalid", {15'd0, f_p1_rvalid}, 16'd1);
    chk("fp tail p1_rdata", {8'd0, f_p1_rdata}, 16'h005A);
    chk("fp tail p0_rvalid", {15'd0, f_p0_rvalid}, 16'd0);
    next_cycle();

    // ---- counter saturation on the round-robin instance ----
    rst = 1'b1;
    p0_req = 1; p0_we = 0; p0_addr = 8'h01;
    p1_req = 1; p1_we = 0; p1_addr = 8'h02;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("sat start", conflict_cnt, 16'h0000);
    for (int n = 0; n < 65534; n++) next_cycle();
    @(negedge clk);
    chk("sat near", conflict_cnt, 16'hFFFE);
    next_cycle();
    @(negedge clk);
    chk("sat reach", conflict_cnt, 16'hFFFF);
    for (int n = 0; n < 3; n++) begin
      next_cycle();
      @(negedge clk);
      chk($sformatf("sat hold%0d", n), conflict_cnt, 16'hFFFF);
    end
    p0_req = 0; p1_req = 0;
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arb.md
# dmem_arb

Two-port arbiter that shares the single 256 x 8 data RAM (synchronous read, synchronous write, one access per cycle) between two requesters: port 0 (CPU load/store unit) and port 1 (debug/DMA loader). It grants at most one access per cycle and drives the RAM command lines. It routes read data back to the requesting port one cycle later with a valid strobe, and counts contention cycles for performance monitoring. It sits between the requesters and the RAM instance in the processor top level.

## Interface
Parameters:
- FIXED_PRIO, 0, arbitration policy: 0 = round-robin, 1 = port 0 always wins.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- p0_req, p1_req  in  1  access request; held high until granted.
- p0_we, p1_we  in  1  1 = write, 0 = read; valid while req is high.
- p0_addr, p1_addr  in  8  byte address.
- p0_wdata, p1_wdata  in  8  write data.
- p0_gnt, p1_gnt  out  1  combinational grant; the access is accepted at the clock edge ending this cycle.
- p0_rvalid, p1_rvalid  out  1  registered; read data valid this cycle.
- p0_rdata, p1_rdata  out  8  read data; meaningful only while the matching rvalid is high.
- mem_wen  out  1  RAM write enable.
- mem_waddr  out  8  RAM write address.
- mem_wdata  out  8  RAM write data.
- mem_raddr  out  8  RAM read address.
- mem_rdata  in  8  RAM registered read data, valid the cycle after the address is presented.
- conflict_cnt  out  16  saturating count of cycles in which both ports requested.

## Operation
- State registers:
  - last_gnt (1 bit): port granted most recently.
  - rd_pend0 / rd_pend1: a read was issued last cycle.
  - conflict_cnt.
- Grant logic (combinational, forced to 0 while rst = 1):
  - No requests: no grant.
  - One requester: that port is granted.
  - Both requesting, FIXED_PRIO = 0: grant the port != last_gnt.
  - Both requesting, FIXED_PRIO = 1: grant port 0.
- last_gnt updates to the granted port on any grant and holds otherwise. It resets to 1, so port 0 wins the first tie.
- RAM command for the granted port:
  - Write: mem_wen = 1, mem_waddr = addr, mem_wdata = wdata.
  - Read: mem_wen = 0, mem_raddr = addr.
  - With no grant: mem_wen = 0; addresses and data are don't-care (driven 0).
- Read return:
  - rd_pendX <= gnt_X & ~we_X.
  - pX_rvalid = rd_pendX.
  - pX_rdata = mem_rdata when rd_pendX, else 0.
- Write-then-read ordering: a read granted in the cycle after a write to the same address returns the new data, because the RAM commits the write at the edge ending the write cycle. No forwarding logic is needed, since only one access occurs per cycle.
- conflict_cnt increments by 1 in each cycle where p0_req & p1_req is high. It saturates at 16'hFFFF.

## Timing
- Reset values (all synchronous, applied at the first edge with rst = 1):
  - rvalid = 0, rd_pend = 0.
  - last_gnt = 1.
  - conflict_cnt = 0.
  - mem_wen = 0, mem_waddr = mem_raddr = mem_wdata = 0.
  - gnt = 0 while rst is high.
- Read latency:
  - Request granted in cycle N → pX_rvalid high in cycle N+1, for exactly one cycle.
  - Back-to-back grants to the same port give rvalid in consecutive cycles.
- Write latency: granted in cycle N → data visible to a read granted in cycle N+1.
- Throughput: one access per cycle. Under continuous contention with round-robin, ports alternate every cycle and neither waits more than 1 cycle.
- Requester rule: req, we, addr and wdata stay stable until gnt is sampled high. Dropping req before grant is legal and withdraws the request.
- Reset mid-operation: rst high in cycle N+1 after a read grant in cycle N suppresses that rvalid (rvalid = 0 in cycle N+1).

## Test plan
- Reset: assert rst for 2 cycles with both reqs high → gnt = 0, rvalid = 0, mem_wen = 0, conflict_cnt = 0.
- Single port: p0 writes 8'hA5 to 8'h10 (granted cycle N), then reads 8'h10 (cycle N+1) → p0_rvalid = 1 in N+2 with p0_rdata = 8'hA5; p1_rvalid stays 0.
- Round-robin contention: both ports hold read requests to addresses 8'h01 / 8'h02 preloaded with 8'h11 / 8'h22 for 4 cycles → grants in order p0, p1, p0, p1; rdata 11, 22, 11, 22 one cycle later; conflict_cnt = 4.
- Fixed priority (FIXED_PRIO = 1): both request for 3 cycles → p0 granted every cycle, p1_gnt = 0 until p0_req drops; p1 is granted the cycle after.
- Reset mid-read: p1 read granted in cycle N, rst = 1 in N+1 → p1_rvalid = 0 in N+1; last_gnt = 1 after reset, so the next tie grants p0.
- Counter saturation: preload or run conflict_cnt to 16'hFFFF, hold both reqs 3 more cycles → conflict_cnt remains 16'hFFFF.
